// File: rtl/oscilo_pkg.sv
// Shared types and constants for the host<->FPGA byte-serial parameter path.
package oscilo_pkg;

    typedef enum logic [1:0] {IDLE, RECV, DONE, ERR} word_rx_state_t;

    localparam int unsigned UART_BYTE_W = 8;
    localparam int unsigned CLK_HZ      = 50_000_000;

endpackage

// File: rtl/byte_timeout_timer.sv
// Counts enabled cycles since the last clear; expired flags the terminal count.
// TIMEOUT_CYCLES = 0 disables expiry entirely.
module byte_timeout_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
    input  logic clk,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit          USE_TIMEOUT = (TIMEOUT_CYCLES != 0);

    logic [CNT_W-1:0] count;

    always_comb begin
        expired = 1'b0;
        if (USE_TIMEOUT) begin
            expired = (count == CNT_W'(TIMEOUT_CYCLES - 1));
        end
    end

    // Holding at the terminal value means the counter can never wrap.
    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (enable && USE_TIMEOUT && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_word_receive.sv
// Assembles one WORD_BYTES-wide parameter word from UART bytes, MSB first, under the
// command decoder's activate/done handshake, with an inter-byte timeout.
module uart_word_receive
    import oscilo_pkg::*;
#(
    parameter int unsigned WORD_BYTES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
    input  logic                              clk_50mhz,
    input  logic                              reset,
    input  logic                              activate,
    input  logic                              rx_valid,
    input  logic [UART_BYTE_W-1:0]            rx_data,
    output logic                              done,
    output logic                              timeout,
    output logic [UART_BYTE_W*WORD_BYTES-1:0] word,
    output logic [$clog2(WORD_BYTES+1)-1:0]   byte_count
);

    localparam int unsigned WORD_W = UART_BYTE_W * WORD_BYTES;
    localparam int unsigned CNT_W  = $clog2(WORD_BYTES + 1);

    word_rx_state_t    state, state_next;
    logic [WORD_W-1:0] shift, shift_next;
    logic [WORD_W-1:0] word_next;
    logic [CNT_W-1:0]  count_next;
    logic              done_next, timeout_next;
    logic              timer_clear, timer_enable, timer_expired;

    byte_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk_50mhz),
        .clear  (reset | timer_clear),
        .enable (timer_enable),
        .expired(timer_expired)
    );

    always_comb begin
        state_next   = state;
        shift_next   = shift;
        word_next    = word;
        count_next   = byte_count;
        timer_clear  = 1'b1;
        timer_enable = 1'b0;

        unique case (state)
            IDLE: begin
                if (activate) begin
                    shift_next = '0;
                    count_next = '0;
                    state_next = RECV;
                end
            end
            RECV: begin
                if (!activate) begin
                    state_next = IDLE;
                end else if (rx_valid) begin
                    // A byte on the terminal timer cycle still wins over expiry.
                    shift_next = WORD_W'({shift, rx_data});
                    count_next = byte_count + 1'b1;
                    if (byte_count == CNT_W'(WORD_BYTES - 1)) begin
                        word_next  = shift_next;
                        state_next = DONE;
                    end
                end else begin
                    timer_clear  = 1'b0;
                    timer_enable = 1'b1;
                    if (timer_expired) begin
                        state_next = ERR;
                    end
                end
            end
            DONE, ERR: begin
                if (!activate) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        done_next    = (state_next == DONE);
        timeout_next = (state_next == ERR);
    end

    always_ff @(posedge clk_50mhz) begin
        if (reset) begin
            state      <= IDLE;
            shift      <= '0;
            word       <= '0;
            byte_count <= '0;
            done       <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_next;
            shift      <= shift_next;
            word       <= word_next;
            byte_count <= count_next;
            done       <= done_next;
            timeout    <= timeout_next;
        end
    end

endmodule
